// File: rtl/light_scheduler.sv
`timescale 1ns/1ps
// light_scheduler
//
// Two-road traffic light controller with an optional pedestrian walk phase.
// Road A is the rest road: it holds green until road B or a pedestrian asks
// for service. Every phase change goes through yellow and then all-red
// clearance. An elapsed-tick counter times each phase.
//
// Parameters
//   GREEN_MIN  minimum green duration, ticks
//   GREEN_MAX  green duration after which a green yields to a pending request
//   YELLOW_T   yellow duration, ticks
//   ALLRED_T   all-red clearance duration, ticks
//   WALK_T     pedestrian walk duration, ticks
//   TW         elapsed-counter width
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high reset
//   tick     in   one-cycle timebase enable
//   SA       in   road A vehicle sensor
//   SB       in   road B vehicle sensor
//   ped_btn  in   pedestrian request
//   LA       out  road A lamp: green 3'b100, yellow 3'b110, red 3'b111
//   LB       out  road B lamp, same encoding
//   walk     out  pedestrian walk lamp
//   phase    out  current state code
//
// Build option
//   LIGHT_SCHEDULER_PED_EN  when defined, enables the pedestrian request and
//   walk phase. When undefined, ped_btn is ignored, the walk phase can never
//   be entered and walk is tied low.
//
// state     | meaning
// ----------+---------------------------------------------------
// A_GRN     | road A green, B red (rest state)
// A_YEL     | road A yellow, B red
// ALLRED_AB | clearance after A, heading to B (or walk)
// B_GRN     | road B green, A red
// B_YEL     | road B yellow, A red
// ALLRED_BA | clearance after B, heading to A (or walk)
// PED_WALK  | both roads red, walk lamp lit

module light_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int TW        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       SA,
    input  logic       SB,
    input  logic       ped_btn,
    output logic [2:0] LA,
    output logic [2:0] LB,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN     = 3'd0,
        A_YEL     = 3'd1,
        ALLRED_AB = 3'd2,
        B_GRN     = 3'd3,
        B_YEL     = 3'd4,
        ALLRED_BA = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_GRN = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b110;
    localparam logic [2:0] LAMP_RED = 3'b111;

    localparam logic [TW-1:0] GMIN_T  = TW'(GREEN_MIN);
    localparam logic [TW-1:0] GMAX_T  = TW'(GREEN_MAX);
    localparam logic [TW-1:0] YEL_T   = TW'(YELLOW_T);
    localparam logic [TW-1:0] ARED_T  = TW'(ALLRED_T);
    localparam logic [TW-1:0] WLK_T   = TW'(WALK_T);

    // next_road encoding: 0 = road A, 1 = road B
    localparam logic ROAD_A = 1'b0;
    localparam logic ROAD_B = 1'b1;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] elapsed;
    logic [TW-1:0] elapsed_nxt;
    logic          req_b;
    logic          req_b_nxt;
    logic          req_p;
    logic          next_road;
    logic          next_road_nxt;
    logic          state_change;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        next_road_nxt = next_road;
        case (state)
            A_GRN: begin
                // A only gives up green when someone else is waiting
                if ((req_b && ((elapsed >= GMIN_T && !SA) || elapsed >= GMAX_T)) ||
                    (req_p && elapsed >= GMIN_T)) begin
                    state_nxt = A_YEL;
                end
            end
            A_YEL: begin
                if (elapsed == YEL_T) begin
                    state_nxt = ALLRED_AB;
                end
            end
            ALLRED_AB: begin
                if (elapsed == ARED_T) begin
                    next_road_nxt = ROAD_B;
                    state_nxt     = req_p ? PED_WALK : B_GRN;
                end
            end
            B_GRN: begin
                if ((elapsed >= GMIN_T && !SB) || elapsed >= GMAX_T) begin
                    state_nxt = B_YEL;
                end
            end
            B_YEL: begin
                if (elapsed == YEL_T) begin
                    state_nxt = ALLRED_BA;
                end
            end
            ALLRED_BA: begin
                if (elapsed == ARED_T) begin
                    next_road_nxt = ROAD_A;
                    state_nxt     = req_p ? PED_WALK : A_GRN;
                end
            end
            PED_WALK: begin
                if (elapsed == WLK_T) begin
                    state_nxt = (next_road == ROAD_B) ? B_GRN : A_GRN;
                end
            end
            default: begin
                // Unused code 7 (or any corruption) recovers to the rest state
                state_nxt = A_GRN;
            end
        endcase
    end

    assign state_change = (state_nxt != state);

    // Elapsed counter: restarts on every phase change, even on a tick cycle
    always_comb begin
        elapsed_nxt = elapsed;
        if (state_change) begin
            elapsed_nxt = '0;
        end else if (tick && (elapsed != {TW{1'b1}})) begin
            elapsed_nxt = elapsed + TW'(1);
        end
    end

    // Entry into B_GRN serves the B request, so clearing wins over a
    // simultaneous sensor hit.
    always_comb begin
        req_b_nxt = req_b;
        if (state_nxt == B_GRN && state != B_GRN) begin
            req_b_nxt = 1'b0;
        end else if (SB && state != B_GRN) begin
            req_b_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= A_GRN;
            elapsed   <= '0;
            req_b     <= 1'b0;
            next_road <= ROAD_A;
        end else begin
            state     <= state_nxt;
            elapsed   <= elapsed_nxt;
            req_b     <= req_b_nxt;
            next_road <= next_road_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pedestrian request
    // ------------------------------------------------------------------
`ifdef LIGHT_SCHEDULER_PED_EN
    logic req_p_nxt;

    always_comb begin
        req_p_nxt = req_p;
        if (state_nxt == PED_WALK && state != PED_WALK) begin
            req_p_nxt = 1'b0;
        end else if (ped_btn) begin
            req_p_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_p <= 1'b0;
        end else begin
            req_p <= req_p_nxt;
        end
    end
`else
    logic ped_btn_unused;

    assign ped_btn_unused = ped_btn;
    assign req_p          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        LA = LAMP_RED;
        LB = LAMP_RED;
        case (state)
            A_GRN:   LA = LAMP_GRN;
            A_YEL:   LA = LAMP_YEL;
            B_GRN:   LB = LAMP_GRN;
            B_YEL:   LB = LAMP_YEL;
            default: ;
        endcase
    end

`ifdef LIGHT_SCHEDULER_PED_EN
    assign walk = (state == PED_WALK);
`else
    assign walk = 1'b0;
`endif

    assign phase = state;

endmodule

// File: tb/tb_light_scheduler.sv
`timescale 1ns/1ps
// Testbench for light_scheduler. A driver issues one input vector per clock,
// advances a road/stage reference model and queues the expected outputs; a
// monitor on the falling edge pops and compares.
module tb_light_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YEL  = 2;
    localparam int ARED = 1;
    localparam int WLK  = 3;
    localparam int TW   = 8;
    localparam int SAT  = (1 << TW) - 1;

`ifdef LIGHT_SCHEDULER_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    // stage of the reference model
    localparam int ST_GREEN = 0;
    localparam int ST_YEL   = 1;
    localparam int ST_CLEAR = 2;
    localparam int ST_WALK  = 3;

    logic       clk = 1'b0;
    logic       reset, tick, SA, SB, ped_btn;
    logic [2:0] LA, LB, phase;
    logic       walk;

    light_scheduler #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
        .ALLRED_T(ARED), .WALK_T(WLK), .TW(TW)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .SA(SA), .SB(SB),
        .ped_btn(ped_btn), .LA(LA), .LB(LB), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int la;
        int lb;
        int ph;
        int wk;
        int el;
        int rb;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model: which road owns the intersection and which stage it is in
    int m_road, m_stage, m_dest, m_el, m_rb, m_rp;

    task automatic check(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int model_phase();
        if (m_stage == ST_WALK) return 6;
        return m_road * 3 + m_stage;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit sa, input bit sb, input bit pb);
        int  old_ph, new_ph;
        bit  leave;
        exp_t e;
        if (r) begin
            m_road = 0; m_stage = ST_GREEN; m_dest = 0;
            m_el = 0; m_rb = 0; m_rp = 0;
        end else begin
            old_ph = model_phase();
            leave  = 1'b0;
            case (m_stage)
                ST_GREEN:
                    if (m_road == 0)
                        leave = (m_rb != 0 && ((m_el >= GMIN && !sa) || m_el >= GMAX)) ||
                                (m_rp != 0 && m_el >= GMIN);
                    else
                        leave = (m_el >= GMIN && !sb) || m_el >= GMAX;
                ST_YEL:   leave = (m_el == YEL);
                ST_CLEAR: leave = (m_el == ARED);
                default:  leave = (m_el == WLK);
            endcase
            if (leave) begin
                if (m_stage == ST_GREEN) m_stage = ST_YEL;
                else if (m_stage == ST_YEL) m_stage = ST_CLEAR;
                else if (m_stage == ST_CLEAR) begin
                    if (m_rp != 0) begin
                        m_dest  = 1 - m_road;
                        m_stage = ST_WALK;
                    end else begin
                        m_road  = 1 - m_road;
                        m_stage = ST_GREEN;
                    end
                end else begin
                    m_road  = m_dest;
                    m_stage = ST_GREEN;
                end
                m_el = 0;
            end else if (t && m_el < SAT) begin
                m_el++;
            end
            new_ph = model_phase();
            if (new_ph == 3 && old_ph != 3) m_rb = 0;
            else if (sb && old_ph != 3)     m_rb = 1;
            if (PED) begin
                if (new_ph == 6 && old_ph != 6) m_rp = 0;
                else if (pb)                    m_rp = 1;
            end
        end
        e.ph = model_phase();
        e.la = (e.ph == 0) ? 3'b100 : (e.ph == 1) ? 3'b110 : 3'b111;
        e.lb = (e.ph == 3) ? 3'b100 : (e.ph == 4) ? 3'b110 : 3'b111;
        e.wk = (e.ph == 6) ? 1 : 0;
        e.el = m_el;
        e.rb = m_rb;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit t, input bit sa, input bit sb, input bit pb);
        reset = r; tick = t; SA = sa; SB = sb; ped_btn = pb;
        model_step(r, t, sa, sb, pb);
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("LA", int'(LA), e.la);
            check("LB", int'(LB), e.lb);
            check("walk", int'(walk), e.wk);
            check("phase", int'(phase), e.ph);
            check("elapsed", int'(dut.elapsed), e.el);
            check("req_b", int'(dut.req_b), e.rb);
            check("both_nonred", (LA != 3'b111 && LB != 3'b111) ? 1 : 0, 0);
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int wcnt, p6cnt;
        reset = 1'b1; tick = 1'b1; SA = 1'b0; SB = 1'b0; ped_btn = 1'b0;

        // reset state, then idle: A holds green
        cyc(1, 1, 0, 0, 0);
        check("rst_phase", int'(phase), 0);
        check("rst_LA", int'(LA), 3'b100);
        check("rst_LB", int'(LB), 3'b111);
        check("rst_walk", int'(walk), 0);
        for (int n = 1; n <= 50; n++) cyc(0, 1, 0, 0, 0);
        check("idle_phase", int'(phase), 0);

        // single SB pulse, then optional pedestrian pulse during B green
        for (int run = 0; run < 2; run++) begin
            wcnt = 0; p6cnt = 0;
            cyc(1, 1, 0, 0, 0);
            for (int n = 1; n <= 24; n++) begin
                cyc(0, 1, 0, n == 2, run == 1 && n == 12);
                if (walk) wcnt++;
                if (phase == 3'd6) p6cnt++;
                if (n == 4)  check("sb_agrn_hold", int'(phase), 0);
                if (n == 5)  check("sb_ayel", int'(phase), 1);
                if (n == 8)  check("sb_allred_ab", int'(phase), 2);
                if (n == 10) check("sb_bgrn", int'(phase), 3);
                if (n == 14) check("sb_bgrn_hold", int'(phase), 3);
                if (n == 15) check("sb_byel", int'(phase), 4);
                if (n == 18) check("sb_allred_ba", int'(phase), 5);
                if (n == 20) check("sb_exit_ba", int'(phase), (run == 1 && PED) ? 6 : 0);
                if (n == 24) check("sb_back_agrn", int'(phase), 0);
            end
            check("walk_cycles", wcnt, (run == 1 && PED) ? 4 : 0);
            check("phase6_cycles", p6cnt, (run == 1 && PED) ? 4 : 0);
        end

        // both sensors held: max-green alternation
        cyc(1, 1, 0, 0, 0);
        for (int n = 1; n <= 60; n++) begin
            cyc(0, 1, 1, 1, 0);
            if (n == 8)  check("both_agrn_max", int'(phase), 0);
            if (n == 9)  check("both_ayel", int'(phase), 1);
            if (n == 14) check("both_bgrn", int'(phase), 3);
            if (n == 22) check("both_bgrn_max", int'(phase), 3);
            if (n == 23) check("both_byel", int'(phase), 4);
            if (n == 28) check("both_agrn2", int'(phase), 0);
            if (n == 37) check("both_ayel2", int'(phase), 1);
        end

        // reset mid-yellow discards latched req_b
        cyc(1, 1, 0, 0, 0);
        for (int n = 1; n <= 5; n++) cyc(0, 1, 0, n == 2, 0);
        check("pre_rst_ayel", int'(phase), 1);
        check("pre_rst_req_b", int'(dut.req_b), 1);
        cyc(1, 1, 0, 0, 0);
        check("midyel_rst_phase", int'(phase), 0);
        check("midyel_rst_elapsed", int'(dut.elapsed), 0);
        check("midyel_rst_req_b", int'(dut.req_b), 0);
        for (int n = 1; n <= 15; n++) cyc(0, 1, 0, 0, 0);
        check("req_b_lost", int'(phase), 0);

        // elapsed saturation, then max-green yield with SA busy
        for (int n = 1; n <= 300; n++) cyc(0, 1, 0, 0, 0);
        check("elapsed_sat", int'(dut.elapsed), SAT);
        cyc(0, 1, 1, 1, 0);
        check("sat_hold", int'(dut.elapsed), SAT);
        cyc(0, 1, 1, 0, 0);
        check("sat_yield", int'(phase), 1);

        // randomized traffic
        cyc(1, 1, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/light_scheduler.md
LIGHT_SCHEDULER -- requirements
Module: light_scheduler

Interface
REQ-001 The block SHALL have parameter GREEN_MIN, default 8: minimum green duration in ticks.
REQ-002 The block SHALL have parameter GREEN_MAX, default 32: green duration in ticks after which a green yields to a pending opposite request.
REQ-003 The block SHALL have parameter YELLOW_T, default 3: yellow duration in ticks.
REQ-004 The block SHALL have parameter ALLRED_T, default 2: all-red clearance duration in ticks.
REQ-005 The block SHALL have parameter WALK_T, default 6: pedestrian walk duration in ticks.
REQ-006 The block SHALL have parameter TW, default 8: elapsed-counter width.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port tick, input, 1 bit: one-cycle timebase enable pulse.
REQ-010 The block SHALL have port SA, input, 1 bit: road A vehicle sensor.
REQ-011 The block SHALL have port SB, input, 1 bit: road B vehicle sensor.
REQ-012 The block SHALL have port ped_btn, input, 1 bit: pedestrian request.
REQ-013 The block SHALL have port LA, output, 3 bits: road A light (green 3'b100, yellow 3'b110, red 3'b111).
REQ-014 The block SHALL have port LB, output, 3 bits: road B light, encoded as for LA.
REQ-015 The block SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-016 The block SHALL have port phase, output, 3 bits: current state code.

Function
REQ-017 The state machine SHALL have these states and codes: A_GRN=0, A_YEL=1, ALLRED_AB=2, B_GRN=3, B_YEL=4, ALLRED_BA=5, PED_WALK=6; codes 7 and other illegal values SHALL go to A_GRN on the next edge.
REQ-018 elapsed (TW bits) SHALL increment on each cycle with tick=1, saturate at all-ones, and clear to 0 on every state change, including when tick=1 in that same cycle.
REQ-019 req_b SHALL set on any cycle with SB=1 while the state is not B_GRN, and SHALL clear on entry to B_GRN; req_p SHALL set on ped_btn=1 and clear on entry to PED_WALK.
REQ-020 A_GRN SHALL go to A_YEL when req_b=1 and either (elapsed>=GREEN_MIN and SA=0) or elapsed>=GREEN_MAX, or when req_p=1 and elapsed>=GREEN_MIN; otherwise A_GRN SHALL hold indefinitely, since A is the rest road.
REQ-021 B_GRN SHALL go to B_YEL when (elapsed>=GREEN_MIN and SB=0) or elapsed>=GREEN_MAX.
REQ-022 A_YEL->ALLRED_AB and B_YEL->ALLRED_BA SHALL occur when elapsed==YELLOW_T.
REQ-023 ALLRED_AB SHALL go to B_GRN and ALLRED_BA SHALL go to A_GRN when elapsed==ALLRED_T, except that req_p=1 at that point SHALL divert to PED_WALK; a 1-bit next_road register SHALL record the destination green.
REQ-024 PED_WALK SHALL go to the green recorded in next_road when elapsed==WALK_T.
REQ-025 Outputs SHALL be Moore-decoded from the state register: A_GRN {green,red}, A_YEL {yellow,red}, B_GRN {red,green}, B_YEL {red,yellow}, ALLRED_AB, ALLRED_BA and PED_WALK {red,red}; walk=1 only in PED_WALK.
REQ-026 LA and LB SHALL never both be non-red in the same cycle.
REQ-027 When req_p and req_b are both pending at an all-red exit, pedestrian service SHALL come first; req_b SHALL be retained.
REQ-028 Sensor and button inputs are synchronous to clk; no synchronizers are required.

Reset
REQ-029 reset=1 at a rising edge SHALL, regardless of tick or state (including mid-yellow or mid-walk), load A_GRN, elapsed=0, req_b=0, req_p=0 and next_road=A.
REQ-030 Reset values SHALL be LA=3'b100, LB=3'b111, walk=0 and phase=0.

Configuration
REQ-031 With macro LIGHT_SCHEDULER_PED_EN defined, the pedestrian logic SHALL be as in REQ-019, REQ-020, REQ-023, REQ-024 and REQ-027.
REQ-032 Without LIGHT_SCHEDULER_PED_EN, the ped_btn port SHALL remain present but be ignored, req_p SHALL be constant 0, PED_WALK SHALL be unreachable and walk SHALL be constant 0.

Verification
(All scenarios use GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, WALK_T=3 and tick=1 every cycle.)
REQ-033 Bench SHALL check: reset, then SA=0 and SB=0 for 50 cycles -> phase=0, LA=100 and LB=111 throughout.
REQ-034 Bench SHALL check: after reset, SB pulsed 1 cycle at cycle 2 with SA=0 -> A_YEL entered at the edge after elapsed reaches 4, then ALLRED_AB, then B_GRN; B_GRN exits after 4 ticks because SB=0.
REQ-035 Bench SHALL check: SA=1 and SB=1 held continuously -> A_GRN lasts until elapsed=8, B_GRN lasts until elapsed=8, and the cycle repeats with no cycle where both roads are non-red.
REQ-036 Bench SHALL check (PED_EN defined): ped_btn pulsed during B_GRN -> B_YEL, ALLRED_BA, PED_WALK with walk=1 for the WALK_T span, then A_GRN.
REQ-037 Bench SHALL check (PED_EN undefined): the same stimulus as REQ-036 -> walk stays 0 and phase never equals 6.
REQ-038 Bench SHALL check: reset asserted for one cycle during A_YEL with tick=1 -> next phase=0, elapsed=0, and the previously latched req_b is lost.
